// File: rtl/banco_registros_if.sv
// Register-file access bus: one write port and two combinational read ports.
// The master drives addresses and write data; the slave returns both read operands.
interface banco_registros_if #(
  parameter int unsigned ANCHO = 32,
  parameter int unsigned NREG  = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic             we;
  logic [AW-1:0]    rd;
  logic [ANCHO-1:0] wd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [ANCHO-1:0] rd1;
  logic [ANCHO-1:0] rd2;

  modport master (
    output we, rd, wd, rs1, rs2,
    input  rd1, rd2
  );

  modport slave (
    input  we, rd, wd, rs1, rs2,
    output rd1, rd2
  );
endinterface

// File: rtl/banco_registros.sv
// Register file: NREG x ANCHO storage, one synchronous write port, two combinational
// read ports, x0 hard-wired to zero, optional same-cycle write-to-read forwarding.
module banco_registros #(
  parameter int unsigned ANCHO  = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 0
) (
  input logic              clk,
  input logic              rst,
  banco_registros_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [ANCHO-1:0] regs_q [NREG];

  // Entry 0 is cleared by reset and never written, but reads of x0 never reach it anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.we && (bus.rd != '0)) begin
      regs_q[bus.rd] <= bus.wd;
    end
  end

  // Forwarding needs rs != 0, which already implies rd != 0 when the addresses match.
  function automatic logic [ANCHO-1:0] leer(input logic [AW-1:0] rs);
    logic [ANCHO-1:0] dato;
    dato = '0;
    if (!rst && (rs != '0)) begin
      if ((BYPASS != 0) && bus.we && (bus.rd == rs)) begin
        dato = bus.wd;
      end else begin
        dato = regs_q[rs];
      end
    end
    return dato;
  endfunction

  always_comb begin
    bus.rd1 = leer(bus.rs1);
    bus.rd2 = leer(bus.rs2);
  end
endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench: two register files (no forwarding / forwarding) fed identical stimulus,
// checked against fixed vectors, directed reset/bypass sequences and a random reference model.
module tb_banco_registros;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        t_we  = 1'b0;
  logic [4:0]  t_rd  = '0;
  logic [31:0] t_wd  = '0;
  logic [4:0]  t_rs1 = '0;
  logic [4:0]  t_rs2 = '0;

  logic [31:0] mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  banco_registros_if #(.ANCHO(32), .NREG(32)) bus0 ();
  banco_registros_if #(.ANCHO(32), .NREG(32)) bus1 ();

  assign bus0.we = t_we;  assign bus0.rd = t_rd;  assign bus0.wd = t_wd;
  assign bus0.rs1 = t_rs1; assign bus0.rs2 = t_rs2;
  assign bus1.we = t_we;  assign bus1.rd = t_rd;  assign bus1.wd = t_wd;
  assign bus1.rs1 = t_rs1; assign bus1.rs2 = t_rs2;

  banco_registros #(.ANCHO(32), .NREG(32), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  banco_registros #(.ANCHO(32), .NREG(32), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural view of a read: what the register file must present right now.
  function automatic logic [31:0] mref(input bit byp, input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (byp && t_we && t_rd == a) return t_wd;
    return mem[a];
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, " nb rd1"}, bus0.rd1, mref(1'b0, t_rs1));
    chk({tag, " nb rd2"}, bus0.rd2, mref(1'b0, t_rs2));
    chk({tag, " by rd1"}, bus1.rd1, mref(1'b1, t_rs1));
    chk({tag, " by rd2"}, bus1.rd2, mref(1'b1, t_rs2));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  // Advance through one rising edge, commit the write in the model, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && t_we && t_rd != 5'd0) mem[t_rd] = t_wd;
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    t_we = we; t_rd = rd; t_wd = wd; t_rs1 = rs1; t_rs2 = rs2;
  endtask

  initial begin
    clear_mem();
    // Expected values are the pre-edge outputs of the non-forwarding instance.
    tbl[0]  = '{1'b1, 5'd1, 32'hAAAAAAAA, 5'd1, 5'd2, 32'h00000000, 32'h00000000};
    tbl[1]  = '{1'b1, 5'd2, 32'h55555555, 5'd1, 5'd2, 32'hAAAAAAAA, 32'h00000000};
    tbl[2]  = '{1'b0, 5'd0, 32'h00000000, 5'd1, 5'd2, 32'hAAAAAAAA, 32'h55555555};
    tbl[3]  = '{1'b0, 5'd0, 32'h00000000, 5'd2, 5'd1, 32'h55555555, 32'hAAAAAAAA};
    tbl[4]  = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd1, 32'h00000000, 32'hAAAAAAAA};
    tbl[5]  = '{1'b1, 5'd3, 32'h87654321, 5'd0, 5'd2, 32'h00000000, 32'h55555555};
    tbl[6]  = '{1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd0, 32'h87654321, 32'h00000000};
    tbl[7]  = '{1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd0, 32'h87654321, 32'h00000000};
    tbl[8]  = '{1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd0, 32'h87654321, 32'h00000000};
    tbl[9]  = '{1'b1, 5'd4, 32'h11111111, 5'd3, 5'd3, 32'h87654321, 32'h87654321};
    tbl[10] = '{1'b1, 5'd4, 32'h22222222, 5'd4, 5'd4, 32'h11111111, 32'h11111111};
    tbl[11] = '{1'b0, 5'd0, 32'h00000000, 5'd4, 5'd1, 32'h22222222, 32'hAAAAAAAA};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset rd1", bus0.rd1, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].rs1, tbl[i].rs2);
      #1;
      chk($sformatf("vec%0d rd1", i), bus0.rd1, tbl[i].e1);
      chk($sformatf("vec%0d rd2", i), bus0.rd2, tbl[i].e2);
      chk_model($sformatf("vec%0d", i));
      tick();
    end

    // Forwarding before the edge, then reset landing during the write.
    drive(1'b1, 5'd4, 32'h44444444, 5'd4, 5'd4);
    #1;
    chk("bypass rd1", bus1.rd1, 32'h44444444);
    chk("bypass rd2", bus1.rd2, 32'h44444444);
    chk("nobypass old", bus0.rd1, 32'h22222222);
    rst = 1'b1;
    clear_mem();
    #1;
    chk("rst bypass rd1", bus1.rd1, 32'h0);
    chk("rst bypass rd2", bus1.rd2, 32'h0);
    chk("rst nobypass rd1", bus0.rd1, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 5'd7, 32'hCAFEF00D, 5'd4, 5'd4);
    #1 chk("write lost x4", bus0.rd1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1;
    chk("first write nb", bus0.rd1, 32'hCAFEF00D);
    chk("first write by", bus1.rd2, 32'hCAFEF00D);

    // Asynchronous clear mid-cycle, well before the next rising edge.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1 chk("x5 loaded", bus0.rd1, 32'hDEADBEEF);
    #1 rst = 1'b1;
    clear_mem();
    #1 chk("async clear", bus0.rd1, 32'h0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      t_rs1 = a[4:0];
      t_rs2 = 5'(31 - a);
      #1;
      chk($sformatf("clr x%0d", a), bus0.rd1, 32'h0);
      chk($sformatf("clr by x%0d", a), bus1.rd2, 32'h0);
    end

    // Random traffic, occasional whole-cycle resets.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) t_rs1 = t_rd;
      if ($urandom_range(0, 3) == 0) t_rs2 = t_rs1;
      rst = ($urandom_range(0, 49) == 0);
      if (rst) clear_mem();
      #1 chk_model($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/banco_registros.md
# banco_registros

Register file for the single-cycle datapath: 32 general-purpose 32-bit registers, one synchronous write port, two asynchronous read ports. It sits between instruction decode and the ALU operand multiplexers. It is the write-decode/storage counterpart of the datapath's 2:1 selection muxes: the write port demultiplexes one result onto one of 32 registers, and the read ports select operands back out. Register x0 reads as zero at all times.

## Interface

Parameters:
- `ANCHO`, 32: data width of every register and data port.
- `NREG`, 32: number of registers. Must be a power of two; address width is log2(`NREG`).
- `BYPASS`, 0: when 1, a write that is in progress forwards to a matching read port in the same cycle.

Ports:
- `clk`  in  1  single clock, rising-edge active.
- `rst`  in  1  reset, asynchronous, active-high; clears all registers.
- `we`  in  1  write enable, sampled on the rising edge of `clk`.
- `rd`  in  log2(NREG)  write address.
- `wd`  in  ANCHO  write data.
- `rs1`  in  log2(NREG)  read address, port 1.
- `rs2`  in  log2(NREG)  read address, port 2.
- `rd1`  out  ANCHO  read data, port 1 (combinational).
- `rd2`  out  ANCHO  read data, port 2 (combinational).

## Operation

- Storage:
  - `NREG` registers, each `ANCHO` bits.
  - Register 0 is not writable and always reads 0.
- Write:
  - On a rising edge of `clk` with `we`=1, `rst`=0 and `rd`≠0, register[`rd`] ← `wd`.
  - `we`=1 with `rd`=0 is accepted and discarded; no state changes.
  - `we`=0: no register changes, whatever `rd` and `wd` hold.
- Read:
  - `rd1` = (`rs1`=0) ? 0 : register[`rs1`]; `rd2` likewise from `rs2`.
  - Both ports are independent. They may address the same register and must return identical values.
- Bypass:
  - `BYPASS`=1, `we`=1, `rd`≠0 and `rs1`=`rd`: `rd1` = `wd` combinationally, before the clock edge. The same rule applies to `rs2`/`rd2`.
  - `BYPASS`=0: reads return the stored value. The new value appears only after the writing edge.
- Reset:
  - `rst`=1 clears every register to 0 immediately, without waiting for a clock edge.
  - While `rst`=1, writes are ignored and `rd1` = `rd2` = 0 for any address, including when a bypass would otherwise apply.
  - `rst` rising during the cycle of a write: the write is lost and the register stays 0.
  - Release of `rst` is synchronous-safe: the first write is accepted on the first rising edge with `rst`=0.

## Timing

- Write latency:
  - 1 edge. Data written at edge N is visible on `rd1`/`rd2` right after edge N, within the same combinational settle.
  - With `BYPASS`=1 the data is visible before edge N.
- Read latency: 0 cycles. The outputs follow `rs1`/`rs2` combinationally, with no registered output stage.
- Simultaneous read and write of the same address (`BYPASS`=0):
  - Before the edge, the read returns the old value.
  - After the edge, it returns the new value.
  - No X is permitted at any point.
- Back-to-back writes to the same register on consecutive edges: the last write wins, with no intermediate loss.
- Output reset values: `rd1` = `rd2` = 32'h00000000 for any `rs1`/`rs2` while `rst` is asserted and until the first write after reset.
- No internal state machine. State is only the register array; the block has no busy or stall condition.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle after loading x5 = 32'hDEADBEEF -> `rd1` (`rs1`=5) drops to 0 before the next `clk` edge; all 32 registers read 0 after release.
- **Write/read both ports:** write x1 = 32'hAAAAAAAA and x2 = 32'h55555555 on two edges; `rs1`=1, `rs2`=2 -> `rd1` = AAAAAAAA, `rd2` = 55555555; swap addresses -> values swap.
- **x0 protection:** `we`=1, `rd`=0, `wd` = 32'h12345678 -> `rd1` (`rs1`=0) = 0 after the edge; no other register changes.
- **Write-enable gating:** x3 = 32'h87654321, then `we`=0 with `rd`=3, `wd`=FFFFFFFF for 3 edges -> x3 still reads 87654321.
- **Same-cycle read/write, `BYPASS`=0:** x4 = 32'h11111111, then `we`=1, `rd`=4, `wd` = 32'h22222222, `rs1`=4 -> `rd1` = 11111111 before the edge, 22222222 after it.
- **Same-cycle read/write, `BYPASS`=1:** same stimulus -> `rd1` = 22222222 before the edge; `rd2` with `rs2`=4 matches. With `rst`=1 asserted during the write, both outputs read 0.
